// File: rtl/addsub_arbiter_pkg.sv
// Shared encodings for the add/sub arbiter: FSM states and operation codes.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Signed add/subtract of two W-bit operands into an exact W+1-bit result.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module addsub_core
  import addsub_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W:0]   y
);

  logic [W:0] a_ext;
  logic [W:0] b_ext;

  // One extra sign bit makes every sum/difference representable.
  assign a_ext = {a[W-1], a};
  assign b_ext = {b[W-1], b};

  // Select add or subtract on the sign-extended operands.
  always_comb begin
    y = (op == OP_ADD) ? (a_ext + b_ext) : (a_ext - b_ext);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin shares one add/sub core among N_REQ valid/ready requesters.
// Latency: accept at T, result valid at T+2; at most one operation per 3 cycles.
// Backpressure: holds the response (and blocks new grants) until rsp_ready of the granted requester.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_op,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W:0]         rsp_data,
  output logic               busy,
  output logic [7:0]         done_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic [IW-1:0] g_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          op_q;
  logic [W:0]    core_y;
  logic          rsp_hs;

  addsub_core #(.W(W)) u_core (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (core_y)
  );

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_any && req_valid[(int'(last_grant) + k) % N_REQ]) begin
        grant_any = 1'b1;
        grant_idx = IW'((int'(last_grant) + k) % N_REQ);
      end
    end
  end

  assign rsp_hs = (state == ST_RESP) && rsp_ready[g_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs; req_ready is masked during reset so nothing looks accepted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == ST_IDLE && grant_any && !rst) req_ready[grant_idx] = 1'b1;
    if (state == ST_RESP)                      rsp_valid[g_q]       = 1'b1;
    busy = (state != ST_IDLE);
  end

  // Operand capture, result register, grant history and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      g_q        <= '0;
      last_grant <= IW'(N_REQ - 1);
      rsp_data   <= '0;
      done_count <= 8'd0;
    end else begin
      if (state == ST_IDLE && grant_any) begin
        a_q  <= req_a[int'(grant_idx)*W +: W];
        b_q  <= req_b[int'(grant_idx)*W +: W];
        op_q <= req_op[grant_idx];
        g_q  <= grant_idx;
      end
      if (state == ST_EXEC) rsp_data <= core_y;
      if (rsp_hs) begin
        done_count <= done_count + 8'd1;
        last_grant <= g_q;
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_op;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W:0]     rsp_data;
  logic           busy;
  logic [7:0]     done_count;

  int n_chk  = 0;
  int n_pass = 0;

  addsub_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_op[idx]       = op;
  endtask

  // One full transaction from a lone requester, checked at every stage.
  task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, input logic [W:0] exp, input int cnt);
    set_req(idx, a, b, op);
    req_valid = N'(1 << idx);
    rsp_ready = '1;
    #1;
    chk("grant", req_ready, 32'(1 << idx));
    step();
    req_valid = '0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    step();
    #1;
    chk("rsp_valid", rsp_valid, 32'(1 << idx));
    chk("rsp_data", rsp_data, exp);
    step();
    #1;
    chk("done_count", done_count, cnt);
    chk("rsp_valid_clear", rsp_valid, 0);
  endtask

  // Unchecked transaction used only to advance the completion counter.
  task automatic fast_op();
    req_valid = 4'b0001;
    rsp_ready = '1;
    step();
    req_valid = '0;
    step();
    step();
  endtask

  logic [W:0] exp_rr [4];

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_count", done_count, 0);

    // Single add and signed extremes: 3+4=7, -8-7=-15, 7-(-8)=15, -8+-8=-16, -1+1=0
    do_op(0, 4'd3,    4'd4,    1'b0, 5'b00111, 1);
    do_op(1, 4'b1000, 4'd7,    1'b1, 5'b10001, 2);
    do_op(2, 4'd7,    4'b1000, 1'b1, 5'b01111, 3);
    do_op(0, 4'b1000, 4'b1000, 1'b0, 5'b10000, 4);
    do_op(3, 4'b1111, 4'd1,    1'b0, 5'b00000, 5);

    // Round robin with all requesters valid; last grant was 3 so order is 0,1,2,3,0.
    // Requester i: a=i+1, b=2, op=i[0] -> 3, 0, 5, 2
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'd2, i[0]);
    exp_rr[0] = 5'd3; exp_rr[1] = 5'd0; exp_rr[2] = 5'd5; exp_rr[3] = 5'd2;
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, 32'(1 << (k % N)));
      step();
      #1;
      chk("rr_exec_ready", req_ready, 0);
      step();
      #1;
      chk("rr_rsp_valid", rsp_valid, 32'(1 << (k % N)));
      chk("rr_rsp_data", rsp_data, exp_rr[k % N]);
      step();
    end
    req_valid = '0;
    #1;
    chk("rr_done_count", done_count, 10);

    // Backpressure on requester 1 (5 - (-3) = 8) while requester 0 stays valid.
    set_req(1, 4'd5, 4'b1101, 1'b1);
    req_valid = 4'b0011;
    rsp_ready = 4'b1101;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    step();
    req_valid = 4'b0001;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_rsp_data", rsp_data, 5'b01000);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    req_valid = 4'b0101;
    rsp_ready = '1;
    #1;
    chk("bp_rsp_valid_hold", rsp_valid, 4'b0010);
    step();
    #1;
    chk("bp_done_count", done_count, 11);
    chk("bp_next_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    #1;
    chk("bp_next_data", rsp_data, 5'd5);
    step();
    #1;
    chk("bp_done_count2", done_count, 12);

    // Reset during EXEC: last grant 2 so requester 3 is taken, then discarded.
    req_valid = '1;
    #1;
    chk("rst_mid_grant", req_ready, 4'b1000);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy_exec", busy, 1);
    step();
    #1;
    chk("rst_mid_req_ready", req_ready, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_rsp_data", rsp_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done_count", done_count, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 4'b0001);
    chk("post_rst_rsp_data", rsp_data, 5'd3);
    step();
    #1;
    chk("post_rst_done_count", done_count, 1);

    // Counter wrap 255 -> 0.
    for (int i = 0; i < 254; i++) fast_op();
    #1;
    chk("count_255", done_count, 255);
    fast_op();
    #1;
    chk("count_wrap", done_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
